// File: rtl/conv_mac_sequencer.sv
// rtl/conv_mac_sequencer.sv - sequences an external pipelined MAC into a 1-D valid-mode convolution
module conv_mac_sequencer #(
    parameter int M  = 4,
    parameter int N  = 8,
    parameter int DW = 14,
    parameter int AW = 28
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] s_data,
    input  logic          s_valid,
    output logic          s_ready,
    output logic [AW-1:0] m_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] mac_a,
    output logic [DW-1:0] mac_b,
    output logic          mac_valid_in,
    output logic          mac_clear,
    input  logic [AW-1:0] mac_f,
    input  logic          mac_valid_out,
    output logic          busy
);

    // Counters are wide enough to hold N so one width serves i, j, k and rc.
    localparam int CW  = $clog2(N + 1);
    localparam int WIW = $clog2(M);
    localparam int XIW = $clog2(N);

    typedef enum logic [2:0] {
        LOAD_W,
        LOAD_X,
        CLEAR,
        ISSUE,
        DRAIN,
        OUTPUT
    } state_t;

    state_t state, state_next;

    logic [CW-1:0] i_cnt, j_cnt, k_cnt, rc_cnt;
    logic [CW-1:0] x_idx;
    logic [DW-1:0] w_buf [M];
    logic [DW-1:0] x_buf [N];
    logic          collecting;
    logic          last_pulse;

    assign x_idx      = i_cnt + j_cnt;
    assign collecting = (state == ISSUE) || (state == DRAIN);
    // The M-th valid_out since CLEAR closes the current output.
    assign last_pulse = collecting && mac_valid_out && (rc_cnt == CW'(M - 1));
    assign mac_clear  = reset || (state == CLEAR);
    assign busy       = (state != LOAD_W) && (state != LOAD_X);

    // Next-state decode and per-state outputs.
    always_comb begin
        state_next   = state;
        s_ready      = 1'b0;
        m_valid      = 1'b0;
        mac_valid_in = 1'b0;
        mac_a        = '0;
        mac_b        = '0;
        case (state)
            LOAD_W: begin
                s_ready = 1'b1;
                if (s_valid && (k_cnt == CW'(M - 1))) state_next = LOAD_X;
            end
            LOAD_X: begin
                s_ready = 1'b1;
                if (s_valid && (k_cnt == CW'(N - 1))) state_next = CLEAR;
            end
            CLEAR: state_next = ISSUE;
            ISSUE: begin
                mac_valid_in = 1'b1;
                mac_a        = x_buf[x_idx[XIW-1:0]];
                mac_b        = w_buf[j_cnt[WIW-1:0]];
                if (last_pulse)                     state_next = OUTPUT;
                else if (j_cnt == CW'(M - 1))       state_next = DRAIN;
            end
            DRAIN: begin
                if (last_pulse) state_next = OUTPUT;
            end
            OUTPUT: begin
                m_valid = 1'b1;
                if (m_ready) state_next = (i_cnt == CW'(N - M)) ? LOAD_W : CLEAR;
            end
            default: state_next = LOAD_W;
        endcase
    end

    // State, counters and result register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= LOAD_W;
            i_cnt  <= '0;
            j_cnt  <= '0;
            k_cnt  <= '0;
            rc_cnt <= '0;
            m_data <= '0;
        end else begin
            state <= state_next;
            case (state)
                LOAD_W: begin
                    if (s_valid) k_cnt <= (k_cnt == CW'(M - 1)) ? '0 : k_cnt + 1'b1;
                end
                LOAD_X: begin
                    if (s_valid) begin
                        if (k_cnt == CW'(N - 1)) begin
                            k_cnt <= '0;
                            i_cnt <= '0;
                        end else begin
                            k_cnt <= k_cnt + 1'b1;
                        end
                    end
                end
                CLEAR: begin
                    j_cnt  <= '0;
                    rc_cnt <= '0;
                end
                ISSUE: begin
                    j_cnt <= j_cnt + 1'b1;
                    if (mac_valid_out) rc_cnt <= rc_cnt + 1'b1;
                end
                DRAIN: begin
                    if (mac_valid_out) rc_cnt <= rc_cnt + 1'b1;
                end
                OUTPUT: begin
                    if (m_ready && (i_cnt != CW'(N - M))) i_cnt <= i_cnt + 1'b1;
                end
                default: ;
            endcase
            if (last_pulse) m_data <= mac_f;
        end
    end

    // Operand buffers; contents after reset are irrelevant so they carry no reset.
    always_ff @(posedge clk) begin
        if (!reset && (state == LOAD_W) && s_valid) w_buf[k_cnt[WIW-1:0]] <= s_data;
        if (!reset && (state == LOAD_X) && s_valid) x_buf[k_cnt[XIW-1:0]] <= s_data;
    end

endmodule

// File: tb/tb_conv_mac_sequencer.sv
// tb/tb_conv_mac_sequencer.sv - directed bench for conv_mac_sequencer with a saturating 5-cycle MAC model
module tb_conv_mac_sequencer;

    localparam int M  = 4;
    localparam int N  = 8;
    localparam int DW = 14;
    localparam int AW = 28;
    localparam int L  = 5;
    localparam int NO = N - M + 1;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [DW-1:0]        s_data;
    logic                 s_valid;
    logic                 s_ready;
    logic signed [AW-1:0] m_data;
    logic                 m_valid;
    logic                 m_ready;
    logic [DW-1:0]        mac_a;
    logic [DW-1:0]        mac_b;
    logic                 mac_valid_in;
    logic                 mac_clear;
    logic signed [AW-1:0] mac_f;
    logic                 mac_valid_out;
    logic                 busy;

    conv_mac_sequencer #(.M(M), .N(N), .DW(DW), .AW(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .mac_a        (mac_a),
        .mac_b        (mac_b),
        .mac_valid_in (mac_valid_in),
        .mac_clear    (mac_clear),
        .mac_f        (mac_f),
        .mac_valid_out(mac_valid_out),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Saturating MAC: product enters a 4-deep delay line, accumulates on the 5th edge.
    function automatic logic signed [AW-1:0] mul(input logic signed [DW-1:0] a, input logic signed [DW-1:0] b);
        longint la, lb;
        la = a;
        lb = b;
        return AW'(la * lb);
    endfunction

    function automatic logic signed [AW-1:0] sat_add(input logic signed [AW-1:0] a, input logic signed [AW-1:0] b);
        longint s;
        s = longint'(a) + longint'(b);
        if (s > 134217727)  return 28'sd134217727;
        if (s < -134217728) return -28'sd134217728;
        return AW'(s);
    endfunction

    logic signed [AW-1:0] p1, p2, p3, p4;
    logic                 v1, v2, v3, v4;

    always @(posedge clk) begin
        if (mac_clear) begin
            {v1, v2, v3, v4, mac_valid_out} <= '0;
            p1 <= '0; p2 <= '0; p3 <= '0; p4 <= '0;
            mac_f <= '0;
        end else begin
            v1 <= mac_valid_in;
            p1 <= mul(mac_a, mac_b);
            v2 <= v1; p2 <= p1;
            v3 <= v2; p3 <= p2;
            v4 <= v3; p4 <= p3;
            mac_valid_out <= v4;
            if (v4) mac_f <= sat_add(mac_f, p4);
        end
    end

    int cyc = 0;
    int clear_cnt = 0;
    int clear_cyc = 0;
    int clear_cyc_prev = 0;
    int vo_cnt = 0;

    always @(posedge clk) cyc++;

    // Track CLEAR pulses and valid_out pulses seen since the latest CLEAR.
    always @(negedge clk) begin
        if (mac_clear && !reset) begin
            clear_cnt++;
            clear_cyc_prev = clear_cyc;
            clear_cyc      = cyc;
            vo_cnt         = 0;
        end else if (mac_valid_out) begin
            vo_cnt++;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    int words [M+N];
    int exp_y [NO];

    task automatic load_words(input bit stall);
        int idx = 0;
        int tmo = 0;
        while (idx < M + N && tmo < 300) begin
            @(negedge clk);
            s_valid = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            s_data  = DW'(words[idx]);
            if (s_valid && s_ready) idx++;
            tmo++;
        end
        @(negedge clk);
        s_valid = 1'b0;
        if (idx < M + N) check("load_timeout", idx, M + N);
    endtask

    task automatic run_outputs(input int n_out, input int bp_idx, input bit chk_period);
        int last_clr = clear_cnt;
        for (int r = 0; r < n_out; r++) begin
            bit got = 0;
            for (int t = 0; t < 100 && !got; t++) begin
                @(negedge clk);
                #1;
                if (m_valid) got = 1;
            end
            if (!got) begin
                check("out_timeout", 0, 1);
            end else begin
                check("y", m_data, exp_y[r]);
                check("latency", cyc - clear_cyc, M + L + 1);
                check("vo_count", vo_cnt, M);
                check("clear_pulses", clear_cnt - last_clr, 1);
                last_clr = clear_cnt;
                if (chk_period && r > 0) check("period", clear_cyc - clear_cyc_prev, M + L + 2);
                if (r == bp_idx) begin
                    m_ready = 1'b0;
                    for (int h = 0; h < 10; h++) begin
                        @(negedge clk);
                        #1;
                        check("bp_m_valid", m_valid, 1);
                        check("bp_m_data", m_data, exp_y[r]);
                        check("bp_mac_vin", mac_valid_in, 0);
                    end
                    m_ready = 1'b1;
                end
            end
        end
    endtask

    task automatic set_basic_x();
        for (int q = 0; q < N; q++) words[M+q] = q + 1;
    endtask

    initial begin
        reset   = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_s_ready", s_ready, 1);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_mac_clear", mac_clear, 1);
        check("rst_mac_vin", mac_valid_in, 0);
        check("rst_mac_a", mac_a, 0);
        check("rst_busy", busy, 0);
        @(negedge clk);
        reset = 1'b0;

        // Basic run with period and return-to-load checks.
        for (int q = 0; q < M; q++) words[q] = q + 1;
        set_basic_x();
        exp_y = '{30, 40, 50, 60, 70};
        load_words(1'b0);
        run_outputs(NO, -1, 1'b1);
        @(negedge clk);
        #1;
        check("end_s_ready", s_ready, 1);
        check("end_busy", busy, 0);

        // Positive saturation.
        for (int q = 0; q < M + N; q++) words[q] = 8191;
        exp_y = '{134217727, 134217727, 134217727, 134217727, 134217727};
        load_words(1'b0);
        run_outputs(NO, -1, 1'b0);

        // Negative saturation.
        for (int q = M; q < M + N; q++) words[q] = -8192;
        exp_y = '{-134217728, -134217728, -134217728, -134217728, -134217728};
        load_words(1'b0);
        run_outputs(NO, -1, 1'b0);

        // Backpressure on y[1].
        for (int q = 0; q < M; q++) words[q] = q + 1;
        set_basic_x();
        exp_y = '{30, 40, 50, 60, 70};
        load_words(1'b0);
        run_outputs(NO, 1, 1'b0);

        // Reset during ISSUE of y[2].
        load_words(1'b0);
        run_outputs(2, -1, 1'b0);
        begin
            bit seen = 0;
            for (int t = 0; t < 50 && !seen; t++) begin
                @(negedge clk);
                #1;
                if (mac_valid_in) seen = 1;
            end
            check("issue_seen", seen, 1);
        end
        reset = 1'b1;
        #1;
        check("midrst_mac_clear", mac_clear, 1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_m_valid", m_valid, 0);
        check("midrst_s_ready", s_ready, 1);
        check("midrst_busy", busy, 0);
        check("midrst_m_data", m_data, 0);
        for (int q = 0; q < M; q++) words[q] = 1;
        exp_y = '{10, 14, 18, 22, 26};
        load_words(1'b0);
        run_outputs(NO, -1, 1'b0);

        // Stalled load of the basic set.
        for (int q = 0; q < M; q++) words[q] = q + 1;
        exp_y = '{30, 40, 50, 60, 70};
        load_words(1'b1);
        run_outputs(NO, -1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
